// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one digit per clock via acc*10 + digit, valid/ready on both sides.
// Optional range flag against MAX_VAL is built only when BCD2BIN_RANGE_CHECK_EN is defined.
module bcd_to_binary #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int MAX_VAL    = 2359
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        binary,
  output logic                    digit_err,
  output logic                    range_err
);

  localparam int IN_W  = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  bcd_q, bcd_d;
  logic [BIN_W-1:0] acc_q, acc_d, acc_next;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [BIN_W-1:0] binary_q, binary_d;
  logic             digit_err_q, digit_err_d;
  logic [3:0]       digit;

  function automatic logic [BIN_W-1:0] mul10(input logic [BIN_W-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

  function automatic logic any_bad_digit(input logic [IN_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bad = bad | (b[i*4 +: 4] > 4'd9);
    end
    return bad;
  endfunction

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit = bcd_q[i*4 +: 4];
    end
  end

  // Out-of-range nibbles still flow through; the result is masked at DONE entry.
  assign acc_next = mul10(acc_q) + BIN_W'(digit);

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    binary_d    = binary_q;
    digit_err_d = digit_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = bcd_in;
          acc_d   = '0;
          idx_d   = IDX_W'(NUM_DIGITS - 1);
          err_d   = any_bad_digit(bcd_in);
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_next;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          binary_d    = err_q ? '0 : acc_next;
          digit_err_d = err_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          binary_d    = '0;
          digit_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      binary_q    <= '0;
      digit_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      binary_q    <= binary_d;
      digit_err_q <= digit_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign binary    = binary_q;
  assign digit_err = digit_err_q;

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q;
    if (state_q == CONV && idx_q == '0) begin
      range_err_d = !err_q && (acc_next > BIN_W'(MAX_VAL));
    end else if (out_valid_q && out_ready) begin
      range_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  localparam int unused_max_val = MAX_VAL;
  assign range_err = 1'b0;
`endif

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the display-side binary-to-BCD path.
- Takes packed BCD digit entry (e.g. HHMM from the set-time keypad/buttons) and produces the binary count used by the clock counters.
- Uses an iterative multiply-by-10 accumulate, one digit per clock.
- Valid/ready handshake on both input and output.

Parameters:
- NUM_DIGITS, 4, number of BCD digits accepted; 1..4 supported.
- BIN_W, 14, binary output width; must be >= ceil(log2(10^NUM_DIGITS)) (14 for 4 digits).
- MAX_VAL, 2359, upper legal value; used only when BCD2BIN_RANGE_CHECK_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  converter can accept; high only in IDLE.
- bcd_in  input  4*NUM_DIGITS  packed digits, most significant digit in the top nibble.
- out_valid  output  1  binary/flags valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- binary  output  BIN_W  converted value.
- digit_err  output  1  some input nibble was > 9.
- range_err  output  1  result > MAX_VAL (macro-dependent; see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, binary=0, digit_err=0, range_err=0, accumulator=0, digit index=0. Reset mid-conversion discards all partial results; there is no output for the aborted transfer.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On the edge where in_valid & in_ready: latch bcd_in, clear accumulator, index=NUM_DIGITS-1, set err_latch = OR over all nibbles of (nibble > 9), go to CONV.
- CONV: in_ready=0. Each edge: acc <= acc*10 + digit[index], with acc*10 computed as (acc<<3)+(acc<<1) at BIN_W width. Index decrements. After the edge that consumes digit 0, go to DONE.
- DONE: out_valid=1.
  - binary = acc if err_latch=0, else binary = 0.
  - digit_err = err_latch.
- Outputs are registered and stable for the whole time out_valid=1.
- On the edge where out_valid & out_ready: out_valid <= 0, go to IDLE. in_ready rises the following cycle; a new input is never accepted in the same cycle an output is consumed.
- Latency: accept edge E0; digits consumed on edges E1..E_NUM_DIGITS; out_valid high after edge E_NUM_DIGITS (4 edges after accept for the default). Throughput: one conversion per NUM_DIGITS+2 cycles minimum.
- Arithmetic: with legal BIN_W no overflow is possible for valid digits. Invalid digits still run through the datapath, but the result is forced to 0.
- in_valid dropping while in CONV/DONE has no effect. bcd_in is sampled only at the accept edge.
- out_ready held high continuously: the result is visible for exactly one cycle, then the block returns to IDLE.

Optional Feature:
- Macro: BCD2BIN_RANGE_CHECK_EN.
- Defined: in DONE, range_err = (err_latch=0) & (acc > MAX_VAL). binary still carries the converted value (not clamped). range_err is registered with out_valid and cleared on the handshake and on reset.
- Undefined: range_err tied to 0; no comparator logic generated; port remains for a stable interface.

Test Plan:
- Basic conversion: bcd_in=16'h1234 with in_valid, out_ready=1 -> after 4 edges out_valid=1, binary=1234 (0x04D2), digit_err=0, in_ready=0 throughout conversion.
- Limits: bcd_in=16'h9999 -> binary=9999 (0x270F). bcd_in=16'h0000 -> binary=0. Both with digit_err=0.
- Invalid digit: bcd_in=16'h12A4 -> out_valid=1, binary=0, digit_err=1, range_err=0.
- Backpressure: convert 16'h0815, out_ready=0 for 3 cycles after out_valid -> binary=815 held stable, in_ready stays 0, no new accept while in_valid=1. Raise out_ready -> out_valid drops next edge, in_ready=1 the cycle after.
- Reset mid-op: accept 16'h4321, assert rst_n=0 after 2 CONV edges -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid. A following 16'h0042 -> binary=42.
- Range check (macro defined, MAX_VAL=2359): 16'h2400 -> binary=2400, range_err=1. 16'h2359 -> range_err=0. With macro undefined, 16'h2400 -> range_err=0.
